bus_transfer_controller: RTL and testbench
==========================================

# bus_transfer_controller

Sequencer that moves one 16-bit word per request across the shared register bus: it reads a source register (or takes an immediate), drives the value onto the bus, and pulses exactly one destination register's input enable. It sits directly upstream of the register file. It feeds each register's `bus_register_input` from `bus_data` and each `bus_register_input_en` from one bit of `reg_in_en`. A ready/valid request port faces the control unit.

## Interface
- `DATA_WIDTH`, 16, bus and register word width
- `NUM_REGS`, 8, number of registers on the bus (2..16)
- `SEL_WIDTH`, 4, width of register index fields
---
- `bus_ctrl_clock`  in  1  single clock; all state changes on rising edge
- `bus_ctrl_reset`  in  1  asynchronous, active-low reset
- `req_valid`  in  1  transfer request present
- `req_ready`  out  1  controller can accept a request
- `req_src`  in  SEL_WIDTH  source register index
- `req_dst`  in  SEL_WIDTH  destination register index
- `req_imm_en`  in  1  1 = source is `req_imm`, `req_src` ignored
- `req_imm`  in  DATA_WIDTH  immediate value
- `reg_data_in`  in  NUM_REGS*DATA_WIDTH  flattened register outputs; register i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- `bus_data`  out  DATA_WIDTH  bus value to all register inputs
- `reg_in_en`  out  NUM_REGS  one-hot write enables, at most one bit high
- `done`  out  1  one-cycle pulse on transfer completion
- `err`  out  1  one-cycle pulse on rejected request
- `xfer_count`  out  16  count of completed transfers

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - `req_ready`=1.
  - On `req_valid && req_ready`, latch src, dst, imm_en and imm.
  - Validity check at accept. Invalid if dst >= NUM_REGS, or if !imm_en and src >= NUM_REGS, or if !imm_en and src == dst.
  - Invalid request: pulse `err` the next cycle, stay IDLE, no write, `xfer_count` unchanged.
  - Valid request: go to READ.
- READ:
  - `req_ready`=0.
  - Register `bus_data` <= imm_en ? imm : reg_data_in[src].
  - Go to WRITE.
- WRITE:
  - `reg_in_en`[dst]=1 for exactly this cycle.
  - `bus_data` is held stable, so the destination captures at the end of this cycle.
  - Go to DONE.
- DONE:
  - `done`=1 for one cycle.
  - `xfer_count` increments; 16'hFFFF wraps to 0.
  - Go to IDLE.
- `bus_data` holds its last value in IDLE and is not cleared after a transfer.
- Request inputs are sampled only at the accept edge. Changes during READ, WRITE or DONE are ignored.
- Out-of-range source is never indexed; it is always rejected before READ.

## Timing
- Reset (`bus_ctrl_reset`=0), asynchronous, takes effect immediately:
  - state=IDLE
  - `bus_data`=0, `reg_in_en`=0, `done`=0, `err`=0, `xfer_count`=0
  - `req_ready` reads 1 only once reset is released
- While reset is low, `req_ready`=0.
- Reset asserted during READ or WRITE aborts the transfer. `reg_in_en` drops in the same instant, so no partial write occurs.
- Latency: accept edge = cycle 0, READ = cycle 1, WRITE = cycle 2 (destination captures at its closing edge), DONE = cycle 3. Next accept is possible at the cycle 4 edge.
- Throughput: one transfer per 4 cycles.
- `err` rises the cycle after a rejected accept. `req_ready` stays 1, so back-to-back requests are possible after an error.
- `done` and `reg_in_en` are never high in the same cycle.
- `req_ready` is registered-state derived: high only in IDLE and outside reset.

## Test plan
- Reset released, imm request dst=2, imm=16'hA5A5:
  - `reg_in_en`=8'b00000100 for exactly one cycle at cycle 2, with `bus_data`=16'hA5A5.
  - `done` at cycle 3; `xfer_count`=1.
- Register copy, reg_data_in[5]=16'h1234, src=5, dst=0, imm_en=0:
  - `bus_data`=16'h1234 from cycle 2.
  - `reg_in_en`=8'b00000001 one cycle; `done` pulses.
- Rejections: src=dst=3, imm_en=0; then dst=9:
  - each gives an `err` pulse; `reg_in_en` stays 0, `done` stays 0, `xfer_count` unchanged.
  - `req_ready` remains 1.
- `req_valid` held high continuously with changing src/dst:
  - exactly one accept per 4 cycles; each transfer uses the fields present at its accept edge.
- Reset driven low in the WRITE cycle:
  - `reg_in_en` goes to 0 immediately; no `done` pulse; `xfer_count`=0.
  - After release, `req_ready`=1.
- 65536 immediate transfers: `xfer_count` wraps to 0 on the last one.

Source files
------------

// File: rtl/bus_transfer_controller.sv
// Register-bus transfer sequencer: reads a source register or takes an immediate,
// drives it on the bus and pulses exactly one destination write enable.
module bus_transfer_controller #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_REGS   = 8,
    parameter int SEL_WIDTH  = 4
) (
    input  logic                           bus_ctrl_clock,
    input  logic                           bus_ctrl_reset,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [SEL_WIDTH-1:0]           req_src,
    input  logic [SEL_WIDTH-1:0]           req_dst,
    input  logic                           req_imm_en,
    input  logic [DATA_WIDTH-1:0]          req_imm,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_data_in,
    output logic [DATA_WIDTH-1:0]          bus_data,
    output logic [NUM_REGS-1:0]            reg_in_en,
    output logic                           done,
    output logic                           err,
    output logic [15:0]                    xfer_count
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]            state;
    logic [SEL_WIDTH-1:0]  src_q;
    logic [SEL_WIDTH-1:0]  dst_q;
    logic                  imm_en_q;
    logic [DATA_WIDTH-1:0] imm_q;
    logic [DATA_WIDTH-1:0] bus_q;
    logic                  err_q;
    logic [15:0]           xfer_count_q;
    logic [DATA_WIDTH-1:0] src_word;
    logic [NUM_REGS-1:0]   dst_onehot;
    logic                  accept;
    logic                  req_bad;

    // Rejection is decided on the live request fields, so an out-of-range
    // source never reaches the read mux.
    function automatic logic is_invalid(input logic [SEL_WIDTH-1:0] src,
                                        input logic [SEL_WIDTH-1:0] dst,
                                        input logic                 imm_en);
        logic bad;
        bad = (int'(dst) >= NUM_REGS);
        if (!imm_en && ((int'(src) >= NUM_REGS) || (src == dst)))
            bad = 1'b1;
        return bad;
    endfunction

    assign req_ready = bus_ctrl_reset && (state == S_IDLE);
    assign accept    = req_valid && req_ready;
    assign req_bad   = is_invalid(req_src, req_dst, req_imm_en);

    always_comb begin
        src_word   = '0;
        dst_onehot = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (src_q == SEL_WIDTH'(i))
                src_word = reg_data_in[i*DATA_WIDTH +: DATA_WIDTH];
            dst_onehot[i] = (dst_q == SEL_WIDTH'(i));
        end
    end

    // Request fields are pure data: captured only at the accept edge, never reset.
    always_ff @(posedge bus_ctrl_clock) begin
        if (accept) begin
            src_q    <= req_src;
            dst_q    <= req_dst;
            imm_en_q <= req_imm_en;
            imm_q    <= req_imm;
        end
    end

    always_ff @(posedge bus_ctrl_clock or negedge bus_ctrl_reset) begin
        if (!bus_ctrl_reset) begin
            state        <= S_IDLE;
            bus_q        <= '0;
            err_q        <= 1'b0;
            xfer_count_q <= '0;
        end else begin
            err_q <= accept && req_bad;
            case (state)
                S_IDLE: begin
                    if (accept && !req_bad)
                        state <= S_READ;
                end
                S_READ: begin
                    bus_q <= imm_en_q ? imm_q : src_word;
                    state <= S_WRITE;
                end
                S_WRITE: begin
                    // Count lands together with the done pulse.
                    xfer_count_q <= xfer_count_q + 16'd1;
                    state        <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Enables decode straight from state, so an async reset drops them at once.
    assign reg_in_en  = (state == S_WRITE) ? dst_onehot : '0;
    assign done       = (state == S_DONE);
    assign err        = err_q;
    assign bus_data   = bus_q;
    assign xfer_count = xfer_count_q;

endmodule

// File: tb/tb_bus_transfer_controller.sv
// Scoreboard bench for bus_transfer_controller: stimulus pushes expected
// transfers/rejections, a negedge monitor pops and compares them.
module tb_bus_transfer_controller;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [3:0]   req_src = '0;
    logic [3:0]   req_dst = '0;
    logic         req_imm_en = 1'b0;
    logic [15:0]  req_imm = '0;
    logic [127:0] reg_data_in;
    logic [15:0]  bus_data;
    logic [7:0]   reg_in_en;
    logic         done;
    logic         err;
    logic [15:0]  xfer_count;

    logic [15:0]  regs [8];

    typedef struct {
        bit          is_err;
        logic [7:0]  en;
        logic [15:0] data;
        logic [15:0] count;
        int          acc;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          en_cnt = 0;
    logic [15:0] exp_count = '0;

    bus_transfer_controller #(.DATA_WIDTH(16), .NUM_REGS(8), .SEL_WIDTH(4)) dut (
        .bus_ctrl_clock(clk),
        .bus_ctrl_reset(rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_src(req_src),
        .req_dst(req_dst),
        .req_imm_en(req_imm_en),
        .req_imm(req_imm),
        .reg_data_in(reg_data_in),
        .bus_data(bus_data),
        .reg_in_en(reg_in_en),
        .done(done),
        .err(err),
        .xfer_count(xfer_count)
    );

    always #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    always_comb begin
        reg_data_in = '0;
        for (int i = 0; i < 8; i++) reg_data_in[i*16 +: 16] = regs[i];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event not expected by scoreboard (t=%0t)", name, $time);
    endtask

    // Expected outcome of a request accepted at the coming edge.
    task automatic push_req(input logic [3:0] s, input logic [3:0] d, input logic ie,
                            input logic [15:0] imm);
        exp_t e;
        e.acc = cyc;
        e.is_err = (d >= 8) || (!ie && ((s >= 8) || (s == d)));
        e.en = '0;
        e.data = '0;
        if (!e.is_err) begin
            e.en = 8'd1 << d;
            e.data = ie ? imm : regs[s[2:0]];
            exp_count = exp_count + 16'd1;
        end
        e.count = exp_count;
        q.push_back(e);
    endtask

    task automatic issue(input logic [3:0] s, input logic [3:0] d, input logic ie,
                         input logic [15:0] imm);
        int n = 0;
        @(negedge clk);
        req_src = s; req_dst = d; req_imm_en = ie; req_imm = imm; req_valid = 1'b1;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk("accept_timeout", 32'(req_ready), 32'd1);
        end else begin
            push_req(s, d, ie, imm);
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            chk("drain_timeout", 32'(q.size()), 32'd0);
            q.delete();
        end
        @(negedge clk);
    endtask

    // Monitor
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (reg_in_en != 0) begin
                chk("en_excl_done", 32'(done), 32'd0);
                if (q.size() == 0 || q[0].is_err) begin
                    fail("unexpected_write");
                end else begin
                    chk("write_en", 32'(reg_in_en), 32'(q[0].en));
                    chk("write_data", 32'(bus_data), 32'(q[0].data));
                    chk("write_cycle", cyc, q[0].acc + 2);
                    en_cnt++;
                end
            end
            if (done) begin
                if (q.size() == 0 || q[0].is_err) begin
                    fail("unexpected_done");
                end else begin
                    chk("done_count", 32'(xfer_count), 32'(q[0].count));
                    chk("done_cycle", cyc, q[0].acc + 3);
                    chk("done_bus_hold", 32'(bus_data), 32'(q[0].data));
                    chk("write_pulses", en_cnt, 1);
                    en_cnt = 0;
                    void'(q.pop_front());
                end
            end
            if (err) begin
                if (q.size() == 0 || !q[0].is_err) begin
                    fail("unexpected_err");
                end else begin
                    chk("err_cycle", cyc, q[0].acc + 1);
                    chk("err_count", 32'(xfer_count), 32'(q[0].count));
                    chk("err_ready", 32'(req_ready), 32'd1);
                    void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        int last_acc;
        for (int i = 0; i < 8; i++) regs[i] = 16'hB000 + 16'(i) * 16'h0101;
        regs[5] = 16'h1234;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_bus", 32'(bus_data), 32'd0);
        chk("rst_en", 32'(reg_in_en), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_count", 32'(xfer_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("ready_after_rst", 32'(req_ready), 32'd1);

        // Immediate write and register copy
        issue(4'd0, 4'd2, 1'b1, 16'hA5A5);
        drain();
        chk("count_after_imm", 32'(xfer_count), 32'd1);
        issue(4'd5, 4'd0, 1'b0, 16'hFFFF);
        drain();
        chk("copy_bus_hold", 32'(bus_data), 32'h1234);

        // Rejections, back to back
        issue(4'd3, 4'd3, 1'b0, 16'h0000);
        issue(4'd1, 4'd9, 1'b1, 16'h5555);
        issue(4'd9, 4'd4, 1'b0, 16'h0000);
        drain();
        chk("ready_after_err", 32'(req_ready), 32'd1);
        chk("count_after_err", 32'(xfer_count), 32'd2);

        // req_valid held high with fields changing every cycle
        last_acc = -1;
        for (int k = 0; k < 17; k++) begin
            @(negedge clk);
            req_imm_en = (k % 3) != 0;
            req_src = 4'((k + 3) % 8);
            req_dst = 4'(k % 8);
            req_imm = 16'h2000 + 16'(k);
            req_valid = 1'b1;
            if (req_ready) begin
                if (last_acc >= 0) chk("accept_spacing", cyc - last_acc, 4);
                last_acc = cyc;
                push_req(req_src, req_dst, req_imm_en, req_imm);
            end
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        drain();

        // Reset in the WRITE cycle aborts the transfer
        issue(4'd0, 4'd6, 1'b1, 16'hBEEF);
        begin
            int n = 0;
            while (reg_in_en == 0 && n < 10) begin
                @(posedge clk);
                #1;
                n++;
            end
        end
        chk("write_reached", 32'(reg_in_en), 32'h40);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_en", 32'(reg_in_en), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_count", 32'(xfer_count), 32'd0);
        chk("abort_ready", 32'(req_ready), 32'd0);
        q.delete();
        en_cnt = 0;
        exp_count = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("ready_after_abort", 32'(req_ready), 32'd1);
        repeat (6) @(negedge clk);
        chk("count_after_abort", 32'(xfer_count), 32'd0);

        // Counter wrap: preload near the top instead of 65534 real transfers
        @(negedge clk);
        force dut.xfer_count_q = 16'hFFFE;
        @(negedge clk);
        release dut.xfer_count_q;
        exp_count = 16'hFFFE;
        issue(4'd0, 4'd7, 1'b1, 16'h0F0F);
        drain();
        chk("count_top", 32'(xfer_count), 32'hFFFF);
        issue(4'd0, 4'd1, 1'b1, 16'hF0F0);
        drain();
        chk("count_wrapped", 32'(xfer_count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
